// File: rtl/hilo_mult_sequencer.sv
// Shift-add HI/LO multiplier sequencer for mult/multu: IDLE -> RUN (WIDTH steps) -> FIX (sign) -> WRITE.
// Define HILO_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module hilo_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIX   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   step_acc, step_mplr;
  logic [2*WIDTH-1:0] step_prod, run_prod, prod_neg;
  logic               last_iter;

  // Signed operands run as magnitudes; the most negative value maps onto itself.
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  assign sum       = mplr_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
  assign step_acc  = sum[WIDTH:1];
  assign step_mplr = {sum[0], mplr_q[WIDTH-1:1]};
  assign step_prod = {step_acc, step_mplr};
  assign prod_neg  = -{acc_q, mplr_q};

`ifdef HILO_EARLY_TERM_EN
  logic [CNT_W-1:0] remain;
  logic [WIDTH-1:0] remain_mask;
  logic             early_hit;

  // After this step, the low 'remain' bits of the multiplier are still unconsumed.
  assign remain      = LAST - cnt_q;
  assign remain_mask = ~({WIDTH{1'b1}} << remain);
  assign early_hit   = (step_mplr & remain_mask) == '0;
  assign run_prod    = early_hit ? (step_prod >> remain) : step_prod;
  assign last_iter   = early_hit;
`else
  assign run_prod  = step_prod;
  assign last_iter = (cnt_q == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    hi_we = (state_q == S_WRITE);
    lo_we = hi_we;
    done  = hi_we;
    // HI/LO only settle at the end of WRITE, so readers are held through it.
    stall = busy & (start | mf_req);
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mag_a;
          mplr_d  = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
      end
      S_RUN: begin
        {acc_d, mplr_d} = run_prod;
        cnt_d           = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        if (neg_q) {acc_d, mplr_d} = prod_neg;
      end
      S_WRITE: begin
        hi_d = acc_q;
        lo_d = mplr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Bench for hilo_mult_sequencer: directed and random multiplies against a 64-bit arithmetic model.
// Honours HILO_EARLY_TERM_EN for the expected write cycle.
module tb_hilo_mult_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mf_req;
  logic         busy;
  logic         stall;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         done;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] prev_p;

  hilo_mult_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .mf_req(mf_req), .busy(busy), .stall(stall),
    .hi_we(hi_we), .lo_we(lo_we), .hi_out(hi_out), .lo_out(lo_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Product mod 2^64 of the operands extended according to signedness.
  function automatic logic [63:0] model_prod(input bit s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] px, py;
    px = s ? {{32{x[31]}}, x} : {32'b0, x};
    py = s ? {{32{y[31]}}, y} : {32'b0, y};
    return px * py;
  endfunction

  // Cycle (counted from the start cycle as 0) in which the write strobe appears.
  function automatic int exp_latency(input bit s, input logic [31:0] y);
    logic [31:0] m;
    int k;
    m = (s && y[31]) ? -y : y;
    k = 1;
    while (k < W && (m >> k) != 0) k++;
`ifndef HILO_EARLY_TERM_EN
    k = W;
`endif
    return k + 2;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // mode 0: mf_req in cycle 5 and the write cycle, a stray start in cycle 10.
  // mode 1: random start/mf_req/operand noise while busy.
  task automatic do_mult(input bit s, input logic [31:0] av, input logic [31:0] bv, input int mode);
    logic [63:0] exp_p;
    int exp_wc;
    int wc;
    exp_p  = model_prod(s, av, bv);
    exp_wc = exp_latency(s, bv);
    @(negedge clk);
    start = 1'b1; is_signed = s; a = av; b = bv; mf_req = 1'b1;
    #1;
    check("idle_stall", stall, 0);
    check("idle_busy", busy, 0);
    @(posedge clk);
    wc = 0;
    for (int n = 1; n <= exp_wc + 2 && wc == 0; n++) begin
      @(negedge clk);
      if (mode == 0) begin
        start  = (n == 10);
        mf_req = (n == 5) || (n == exp_wc);
        if (n == 10) begin a = 32'd2; b = 32'd3; end
      end else begin
        start     = ($urandom_range(0, 3) == 0);
        mf_req    = 1'($urandom_range(0, 1));
        is_signed = 1'($urandom_range(0, 1));
        a         = $urandom;
        b         = $urandom;
      end
      #1;
      check("busy", busy, 1);
      check("stall", stall, 64'(start | mf_req));
      check("hi_we", hi_we, 64'(n == exp_wc));
      check("lo_we", lo_we, 64'(n == exp_wc));
      check("done", done, 64'(n == exp_wc));
      if (hi_we) begin
        wc = n;
        check("hold_old", {hi_out, lo_out}, prev_p);
      end
    end
    check("write_cycle", 64'(wc), 64'(exp_wc));
    @(negedge clk);
    start = 1'b0; mf_req = 1'b1;
    #1;
    check("post_busy", busy, 0);
    check("post_stall", stall, 0);
    check("post_we", {hi_we, lo_we, done}, 0);
    check("product", {hi_out, lo_out}, exp_p);
    prev_p = exp_p;
    mf_req = 1'b0;
  endtask

  task automatic reset_mid_op();
    logic [31:0] bv;
    bv = $urandom | 32'h8000_0000;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = $urandom; b = bv;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 20) rst = 1'b1;
      #1;
      check("rst_run_we", hi_we, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_hilo", {hi_out, lo_out}, 0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      check("rst_no_we", {hi_we, busy}, 0);
    end
    prev_p = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; mf_req = 1'b0;
    prev_p = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mf_req = 1'b1;
    #1;
    check("rst_busy0", busy, 0);
    check("rst_stall0", stall, 0);
    check("rst_we0", {hi_we, lo_we, done}, 0);
    check("rst_out0", {hi_out, lo_out}, 0);
    rst = 1'b0; mf_req = 1'b0;

    do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("dir_ff_hi", hi_out, 32'hFFFF_FFFE);
    check("dir_ff_lo", lo_out, 32'h0000_0001);
    do_mult(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    check("dir_neg_hi", hi_out, 32'hFFFF_FFFF);
    check("dir_neg_lo", lo_out, 32'hFFFF_FFEB);
    do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    check("dir_min_s", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
    do_mult(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    check("dir_min_u", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
    do_mult(1'b0, 32'd5, 32'd0, 0);
    do_mult(1'b0, 32'd5, 32'd4, 0);
    check("dir_20", {hi_out, lo_out}, 64'd20);

    reset_mid_op();

    for (int i = 0; i < 24; i++) begin
      do_mult(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
